// File: rtl/hdmi_aux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hdmi_aux_pkg
// Brief   : Shared state encoding, slot boundaries and BCH step for the HDMI aux scheduler.
// Revision: 1.0
// ============================================================================
package hdmi_aux_pkg;

    // G(x)=1+x^6+x^7+x^8, bit-reversed because the LFSR shifts LSB-first
    localparam logic [7:0] BCH_POLY     = 8'h83;
    localparam logic [4:0] HDR_ECC_SLOT = 5'd24;
    localparam logic [4:0] SUB_ECC_SLOT = 5'd28;
    localparam logic [4:0] LAST_SLOT    = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_SEND  = 2'd2,
        ST_DRAIN = 2'd3
    } aux_state_t;

    function automatic logic [7:0] bch_step(input logic [7:0] state, input logic din);
        logic fb;
        fb = state[0] ^ din;
        return (state >> 1) ^ (fb ? BCH_POLY : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_aux_scheduler_bch_ecc.sv
`default_nettype none
// ============================================================================
// Module  : aux_bch_ecc
// Brief   : Registered BCH pass-through; data slots feed the LFSR, ECC slots shift parity out.
// Revision: 1.0
// ============================================================================
module aux_bch_ecc
    import hdmi_aux_pkg::*;
#(
    parameter int BITS_PER_CLK = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    first,
    input  logic                    ecc_phase,
    input  logic [BITS_PER_CLK-1:0] din,
    output logic [BITS_PER_CLK-1:0] dout
);

    logic [7:0]              r_lfsr;
    logic [7:0]              w_base;
    logic [7:0]              w_next;
    logic [BITS_PER_CLK-1:0] w_out;

    always_comb begin
        w_base = first ? 8'h00 : r_lfsr;
        w_next = w_base;
        w_out  = din;
        if (ecc_phase) begin
            w_out  = w_base[BITS_PER_CLK-1:0];
            w_next = w_base >> BITS_PER_CLK;
        end else begin
            for (int i = 0; i < BITS_PER_CLK; i++) begin
                w_next = bch_step(w_next, din[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 8'h00;
            dout   <= '0;
        end else if (run) begin
            r_lfsr <= w_next;
            dout   <= w_out;
        end else begin
            dout   <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hdmi_aux_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : hdmi_aux_scheduler
// Brief   : Data-island packet arbiter/sequencer with BCH insertion; optional
//           round-robin arbitration via HDMI_AUX_ROUND_ROBIN_EN.
// Revision: 1.0
// ============================================================================
module hdmi_aux_scheduler
    import hdmi_aux_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int PKTS_PER_ISLAND = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   island_req,
    input  logic [NUM_SRC-1:0]     src_ready,
    input  logic [NUM_SRC-1:0]     src_header,
    input  logic [2*NUM_SRC-1:0]   src_sub0,
    input  logic [2*NUM_SRC-1:0]   src_sub1,
    input  logic [2*NUM_SRC-1:0]   src_sub2,
    input  logic [2*NUM_SRC-1:0]   src_sub3,
    output logic [4:0]             aux_slot,
    output logic                   ae,
    output logic [NUM_SRC-1:0]     enable,
    output logic                   busy,
    output logic                   out_valid,
    output logic                   out_header,
    output logic [1:0]             out_sub0,
    output logic [1:0]             out_sub1,
    output logic [1:0]             out_sub2,
    output logic [1:0]             out_sub3
);

    localparam logic [4:0] LAST_PKT = 5'(PKTS_PER_ISLAND - 1);

    aux_state_t           r_state;
    logic [4:0]           r_pkt_cnt;
    logic                 r_drain_cnt;
    logic [NUM_SRC-1:0]   w_grant;

`ifdef HDMI_AUX_ROUND_ROBIN_EN
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     w_grant_idx;

    // Walk offsets from farthest to nearest so the nearest ready source after r_last wins
    always_comb begin
        int j;
        w_grant     = '0;
        w_grant_idx = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            j = (int'(r_last) + k) % NUM_SRC;
            if (src_ready[j]) begin
                w_grant     = '0;
                w_grant[j]  = 1'b1;
                w_grant_idx = IDX_W'(j);
            end
        end
    end
`else
    always_comb begin
        w_grant = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_ready[i]) begin
                w_grant    = '0;
                w_grant[i] = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pkt_cnt   <= '0;
            r_drain_cnt <= 1'b0;
            aux_slot    <= '0;
            ae          <= 1'b0;
            enable      <= '0;
            busy        <= 1'b0;
`ifdef HDMI_AUX_ROUND_ROBIN_EN
            r_last      <= IDX_W'(NUM_SRC - 1);
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (island_req) begin
                        r_state   <= ST_ARB;
                        busy      <= 1'b1;
                        r_pkt_cnt <= '0;
                    end
                end
                ST_ARB: begin
                    r_state  <= ST_SEND;
                    enable   <= w_grant;
                    ae       <= 1'b1;
                    aux_slot <= '0;
`ifdef HDMI_AUX_ROUND_ROBIN_EN
                    if (|src_ready) begin
                        r_last <= w_grant_idx;
                    end
`endif
                end
                ST_SEND: begin
                    if (aux_slot == LAST_SLOT) begin
                        ae       <= 1'b0;
                        enable   <= '0;
                        aux_slot <= '0;
                        if (r_pkt_cnt == LAST_PKT) begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= 1'b0;
                        end else begin
                            r_state   <= ST_ARB;
                            r_pkt_cnt <= r_pkt_cnt + 5'd1;
                        end
                    end else begin
                        aux_slot <= aux_slot + 5'd1;
                    end
                end
                ST_DRAIN: begin
                    // Two cycles let the last slot's data clear the output pipeline
                    r_drain_cnt <= 1'b1;
                    if (r_drain_cnt) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Source data for slot t arrives at t+1, so the grant and slot are delayed to match
    logic                 r_ae_d1;
    logic [4:0]           r_slot_d1;
    logic [NUM_SRC-1:0]   r_en_d1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ae_d1   <= 1'b0;
            r_slot_d1 <= '0;
            r_en_d1   <= '0;
            out_valid <= 1'b0;
        end else begin
            r_ae_d1   <= ae;
            r_slot_d1 <= aux_slot;
            r_en_d1   <= enable;
            out_valid <= r_ae_d1;
        end
    end

    logic                 w_hdr_bit;
    logic [2*NUM_SRC-1:0] w_sub_in  [4];
    logic [1:0]           w_sub_bits[4];
    logic [1:0]           w_sub_out [4];
    logic                 w_first;
    logic                 w_hdr_ecc;
    logic                 w_sub_ecc;

    assign w_sub_in[0] = src_sub0;
    assign w_sub_in[1] = src_sub1;
    assign w_sub_in[2] = src_sub2;
    assign w_sub_in[3] = src_sub3;

    // A null packet has no enable bit set, which forces all selected data to zero
    always_comb begin
        w_hdr_bit = |(src_header & r_en_d1);
        for (int k = 0; k < 4; k++) begin
            w_sub_bits[k] = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (r_en_d1[i]) begin
                    w_sub_bits[k] = w_sub_bits[k] | w_sub_in[k][2*i +: 2];
                end
            end
        end
    end

    assign w_first   = (r_slot_d1 == 5'd0);
    assign w_hdr_ecc = (r_slot_d1 >= HDR_ECC_SLOT);
    assign w_sub_ecc = (r_slot_d1 >= SUB_ECC_SLOT);

    aux_bch_ecc #(.BITS_PER_CLK(1)) u_hdr_ecc (
        .clk       (clk),
        .rst       (rst),
        .run       (r_ae_d1),
        .first     (w_first),
        .ecc_phase (w_hdr_ecc),
        .din       (w_hdr_bit),
        .dout      (out_header)
    );

    for (genvar k = 0; k < 4; k++) begin : g_sub_ecc
        aux_bch_ecc #(.BITS_PER_CLK(2)) u_sub_ecc (
            .clk       (clk),
            .rst       (rst),
            .run       (r_ae_d1),
            .first     (w_first),
            .ecc_phase (w_sub_ecc),
            .din       (w_sub_bits[k]),
            .dout      (w_sub_out[k])
        );
    end

    assign out_sub0 = w_sub_out[0];
    assign out_sub1 = w_sub_out[1];
    assign out_sub2 = w_sub_out[2];
    assign out_sub3 = w_sub_out[3];

endmodule
`default_nettype wire

// File: tb/tb_hdmi_aux_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_hdmi_aux_scheduler
// Brief   : Scoreboard bench for hdmi_aux_scheduler (default parameters).
// Revision: 1.0
// ============================================================================
module tb_hdmi_aux_scheduler;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        island_req = 1'b0;
    logic [3:0]  src_ready = '0;
    logic [3:0]  src_header = '0;
    logic [7:0]  sub_bus [4];
    logic [4:0]  aux_slot;
    logic        ae;
    logic [3:0]  enable;
    logic        busy;
    logic        out_valid;
    logic        out_header;
    logic [1:0]  out_sub0, out_sub1, out_sub2, out_sub3;

    hdmi_aux_scheduler #(.NUM_SRC(NS), .PKTS_PER_ISLAND(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .island_req (island_req),
        .src_ready  (src_ready),
        .src_header (src_header),
        .src_sub0   (sub_bus[0]),
        .src_sub1   (sub_bus[1]),
        .src_sub2   (sub_bus[2]),
        .src_sub3   (sub_bus[3]),
        .aux_slot   (aux_slot),
        .ae         (ae),
        .enable     (enable),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_header (out_header),
        .out_sub0   (out_sub0),
        .out_sub1   (out_sub1),
        .out_sub2   (out_sub2),
        .out_sub3   (out_sub3)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic       h;
        logic [7:0] s;
    } exp_t;

    exp_t        q_exp[$];
    logic [3:0]  g_log[$];
    logic [23:0] hdr_tab [4];
    logic [55:0] sub_tab [4][4];
    int          n_checks = 0;
    int          n_pass = 0;
    int          m_last = NS - 1;
    int          n_pkt = 0;
    int          n_valid = 0;
    int          exp_slot = 0;
    logic [3:0]  cur_grant = '0;
    logic        ae_h1 = 1'b0;
    logic        ae_h2 = 1'b0;
    logic [4:0]  lat_slot = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] bch_ref(input logic [63:0] data, input int nbits);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            fb = r[0] ^ data[i];
            r  = {1'b0, r[7:1]};
            if (fb) r = r ^ 8'h83;
        end
        return r;
    endfunction

    function automatic int ref_arb(input logic [3:0] rdy);
`ifdef HDMI_AUX_ROUND_ROBIN_EN
        for (int k = 1; k <= NS; k++) if (rdy[(m_last + k) % NS]) return (m_last + k) % NS;
`else
        for (int i = 0; i < NS; i++) if (rdy[i]) return i;
`endif
        return -1;
    endfunction

    // Predict the grant, consume the winner's pending flag and queue all 32 expected slots
    task automatic start_packet();
        int          g;
        logic [23:0] h;
        logic [55:0] sb [4];
        logic [7:0]  eh;
        logic [7:0]  es [4];
        exp_t        e;
        g = ref_arb(src_ready);
        if (g >= 0) begin
            cur_grant    = 4'(1 << g);
            m_last       = g;
            src_ready[g] = 1'b0;
            h = hdr_tab[g];
            for (int k = 0; k < 4; k++) sb[k] = sub_tab[g][k];
        end else begin
            cur_grant = '0;
            h = '0;
            for (int k = 0; k < 4; k++) sb[k] = '0;
        end
        g_log.push_back(cur_grant);
        eh = bch_ref({40'h0, h}, 24);
        for (int k = 0; k < 4; k++) es[k] = bch_ref({8'h0, sb[k]}, 56);
        for (int s = 0; s < 32; s++) begin
            if (s < 24) e.h = h[s];
            else        e.h = eh[s-24];
            for (int k = 0; k < 4; k++) begin
                if (s < 28) e.s[2*k +: 2] = sb[k][2*s +: 2];
                else        e.s[2*k +: 2] = es[k][2*(s-28) +: 2];
            end
            q_exp.push_back(e);
        end
        n_pkt++;
        exp_slot = 0;
    endtask

    // Monitor
    initial forever begin
        logic prev_ae;
        exp_t e;
        @(negedge clk);
        if (rst) begin
            q_exp.delete();
            ae_h1 = 1'b0;
            ae_h2 = 1'b0;
        end else begin
            prev_ae = ae_h1;
            check("valid_lag", out_valid, ae_h2);
            ae_h2 = ae_h1;
            ae_h1 = ae;
            if (ae) begin
                if (!prev_ae) start_packet();
                check("slot", aux_slot, exp_slot);
                check("enable", enable, cur_grant);
                exp_slot++;
            end else begin
                check("idle_slot_en", {aux_slot, enable}, 0);
            end
            if (out_valid) begin
                n_valid++;
                if (q_exp.size() == 0) check("sb_empty", 1, 0);
                else begin
                    e = q_exp.pop_front();
                    check("hdr", out_header, e.h);
                    check("sub", {out_sub3, out_sub2, out_sub1, out_sub0}, e.s);
                end
            end
        end
    end

    // Sources answer one cycle after the slot they saw, with junk in the ECC slots
    initial forever begin
        logic [23:0] hv;
        logic [55:0] sv;
        @(negedge clk);
        lat_slot = aux_slot;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            hv = hdr_tab[i] >> lat_slot;
            src_header[i] = (lat_slot < 5'd24) ? hv[0] : 1'($urandom);
            for (int k = 0; k < 4; k++) begin
                sv = sub_tab[i][k] >> (2 * lat_slot);
                sub_bus[k][2*i +: 2] = (lat_slot < 5'd28) ? sv[1:0] : 2'($urandom);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic pulse_req();
        @(negedge clk);
        island_req = 1'b1;
        @(negedge clk);
        island_req = 1'b0;
        check("busy_after_req", busy, 1);
    endtask

    task automatic run_island();
        pulse_req();
        wait_idle();
    endtask

    task automatic randomize_tables();
        for (int i = 0; i < NS; i++) begin
            hdr_tab[i] = 24'($urandom);
            for (int k = 0; k < 4; k++) sub_tab[i][k] = 56'({$urandom, $urandom});
        end
    endtask

    initial begin
        int p0;
        int n;
        for (int k = 0; k < 4; k++) sub_bus[k] = '0;
        randomize_tables();

        repeat (3) @(negedge clk);
        check("reset_outs", {aux_slot, ae, enable, busy, out_valid, out_header,
                             out_sub3, out_sub2, out_sub1, out_sub0}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Null packets only
        src_ready = 4'b0000;
        n_valid = 0;
        g_log.delete();
        run_island();
        check("null_valid_cnt", n_valid, 64);
        check("null_grants", {g_log.size(), g_log[0], g_log[1]}, {32'd2, 4'b0000, 4'b0000});

        // Two pending sources
        src_ready = 4'b0101;
        g_log.delete();
        run_island();
        check("grants_0101", {g_log.size(), g_log[0], g_log[1]}, {32'd2, 4'b0001, 4'b0100});

        // All pending: arbitration start point depends on the build
        src_ready = 4'b1111;
        g_log.delete();
        run_island();
`ifdef HDMI_AUX_ROUND_ROBIN_EN
        check("grants_1111", {g_log[0], g_log[1]}, {4'b1000, 4'b0001});
`else
        check("grants_1111", {g_log[0], g_log[1]}, {4'b0001, 4'b0010});
`endif

        // Known ECC pattern on source 0, null second packet
        hdr_tab[0] = 24'h000001;
        for (int k = 0; k < 4; k++) sub_tab[0][k] = 56'h00100000FA0000;
        src_ready = 4'b0001;
        g_log.delete();
        run_island();
        check("ecc_grants", {g_log[0], g_log[1]}, {4'b0001, 4'b0000});

        // Random payloads
        randomize_tables();
        src_ready = 4'b1110;
        run_island();

        // island_req while busy is ignored
        src_ready = 4'b0011;
        p0 = n_pkt;
        pulse_req();
        repeat (10) @(negedge clk);
        island_req = 1'b1;
        @(negedge clk);
        island_req = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        check("busy_ignore_pkts", n_pkt - p0, 2);
        check("busy_ignore_idle", busy, 0);

        // Reset in the middle of a packet
        src_ready = 4'b0010;
        pulse_req();
        n = 0;
        while (!(ae && aux_slot == 5'd13) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_slot13", n < 200, 1);
        #2 rst = 1'b1;
        m_last = NS - 1;
        #1;
        check("rst_outs", {aux_slot, ae, enable, busy, out_valid, out_header,
                           out_sub3, out_sub2, out_sub1, out_sub0}, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        randomize_tables();
        src_ready = 4'b0100;
        p0 = n_pkt;
        run_island();
        check("post_rst_pkts", n_pkt - p0, 2);

        repeat (4) @(negedge clk);
        check("sb_drained", q_exp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
